// File: rtl/framebuf_pingpong.sv
// framebuf_pingpong: two-bank ping-pong frame buffer between a camera writer
// and a display reader sharing one clock.
//
// The writer fills bank_wr while the reader scans bank_rd (always ~bank_wr).
// A completed writer frame swaps the banks when the reader also finishes.
// If the reader has not finished, the block parks in WAIT_RD and discards
// writes until the reader finishes its frame.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   wr_en/addr/data camera-side pixel write into bank_wr
//   wr_frame_done   one-cycle pulse, writer finished a frame
//   rd_en/addr      display-side read from bank_rd
//   rd_frame_done   one-cycle pulse, reader finished a frame
//   rd_data/valid   registered read data, one-cycle latency
//   bank_wr/rd      current write / read bank
//   swap_pending    writer frame complete, waiting for reader (WAIT_RD)
//   frame_cnt       completed swaps, wraps modulo 256
//   drop_cnt        discarded writes, saturates at 0xFFFF
module framebuf_pingpong #(
  parameter int AW    = 19,
  parameter int DW    = 16,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_frame_done,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_frame_done,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          bank_wr,
  output logic          bank_rd,
  output logic          swap_pending,
  output logic [7:0]    frame_cnt,
  output logic [15:0]   drop_cnt
);

  typedef enum logic {
    FILL    = 1'b0,
    WAIT_RD = 1'b1
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t state, state_next;

  logic          do_write;
  logic          do_drop;
  logic          do_swap;
  logic          wr_in_range;
  logic          rd_in_range;
  logic [AW:0]   wr_idx;
  logic [AW:0]   rd_idx;

  logic [DW-1:0] mem [0:2*DEPTH-1];

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  // Bank 1 is stacked directly above bank 0; at full depth this is exactly
  // {bank, addr}, and for a reduced DEPTH it keeps storage at 2*DEPTH words.
  assign wr_idx = bank_wr ? (DEPTH_W + {1'b0, wr_addr}) : {1'b0, wr_addr};
  assign rd_idx = bank_rd ? (DEPTH_W + {1'b0, rd_addr}) : {1'b0, rd_addr};

  assign bank_rd      = ~bank_wr;
  assign swap_pending = (state == WAIT_RD);

  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    do_drop    = 1'b0;
    do_swap    = 1'b0;
    unique case (state)
      FILL: begin
        if (wr_en) begin
          if (wr_in_range) do_write = 1'b1;
          else             do_drop  = 1'b1;
        end
        // A write coinciding with wr_frame_done is the frame's last pixel and
        // still lands in the old write bank: the swap only takes effect after
        // this edge.
        if (wr_frame_done) begin
          if (rd_frame_done) do_swap    = 1'b1;
          else               state_next = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (wr_en) do_drop = 1'b1;
        if (rd_frame_done) begin
          do_swap    = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      bank_wr   <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_next;
      if (do_swap) begin
        bank_wr   <= ~bank_wr;
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (do_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Storage has no reset so it maps onto block RAM and keeps frame contents
  // across a reset.
  always_ff @(posedge clk) begin
    if (!rst && do_write) mem[wr_idx] <= wr_data;
  end

  // Reads address the pre-swap bank_rd, which is never the bank being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_in_range ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_framebuf_pingpong.sv
// tb_framebuf_pingpong: directed scoreboard bench for framebuf_pingpong,
// built with a reduced DEPTH of 10 words per bank.
module tb_framebuf_pingpong;

  localparam int TAW    = 4;
  localparam int TDW    = 16;
  localparam int TDEPTH = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           wr_en = 1'b0;
  logic [TAW-1:0] wr_addr = '0;
  logic [TDW-1:0] wr_data = '0;
  logic           wr_frame_done = 1'b0;
  logic           rd_en = 1'b0;
  logic [TAW-1:0] rd_addr = '0;
  logic           rd_frame_done = 1'b0;
  logic [TDW-1:0] rd_data;
  logic           rd_valid;
  logic           bank_wr;
  logic           bank_rd;
  logic           swap_pending;
  logic [7:0]     frame_cnt;
  logic [15:0]    drop_cnt;

  framebuf_pingpong #(
    .AW   (TAW),
    .DW   (TDW),
    .DEPTH(TDEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_frame_done(wr_frame_done),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_frame_done(rd_frame_done),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .bank_wr      (bank_wr),
    .bank_rd      (bank_rd),
    .swap_pending (swap_pending),
    .frame_cnt    (frame_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the buffer state.
  logic [TDW-1:0] m_mem [0:1][0:TDEPTH-1];
  logic           m_bank_wr = 1'b0;
  logic           m_pending = 1'b0;
  logic [7:0]     m_frame = '0;
  logic [15:0]    m_drop = '0;

  // Expected read data, pushed when a read is driven.
  logic [TDW-1:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one clock cycle of stimulus, advances the model and scoreboard.
  task automatic cycle(input bit we, input logic [TAW-1:0] wa,
                       input logic [TDW-1:0] wd, input bit wfd, input bit rfd,
                       input bit re, input logic [TAW-1:0] ra);
    logic brd;
    wr_en = we; wr_addr = wa; wr_data = wd;
    wr_frame_done = wfd; rd_frame_done = rfd;
    rd_en = re; rd_addr = ra;
    brd = ~m_bank_wr;
    if (re) exp_q.push_back((int'(ra) < TDEPTH) ? m_mem[brd][ra] : '0);
    if (we) begin
      if (!m_pending && int'(wa) < TDEPTH) m_mem[m_bank_wr][wa] = wd;
      else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    if (!m_pending) begin
      if (wfd && rfd) begin m_bank_wr = ~m_bank_wr; m_frame = m_frame + 8'd1; end
      else if (wfd) m_pending = 1'b1;
    end else if (rfd) begin
      m_bank_wr = ~m_bank_wr; m_frame = m_frame + 8'd1; m_pending = 1'b0;
    end
    tick();
    wr_en = 1'b0; wr_frame_done = 1'b0; rd_frame_done = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_bank_wr = 1'b0; m_pending = 1'b0; m_frame = '0; m_drop = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bank_wr !== 1'b0) begin errors++; $display("FAIL reset_bank_wr got %b exp 0", bank_wr); end
    checks++; if (bank_rd !== 1'b1) begin errors++; $display("FAIL reset_bank_rd got %b exp 1", bank_rd); end
    checks++; if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", swap_pending); end
    checks++; if (frame_cnt !== 8'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters got frame=%0d drop=%0d exp 0/0", frame_cnt, drop_cnt); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd got valid=%b data=%h exp 0/0000", rd_valid, rd_data); end
  endtask

  task automatic test_basic();
    logic [TDW-1:0] e;
    do_reset();
    cycle(1, 4'd3, 16'hA5A5, 0, 0, 0, '0);
    // Last pixel written in the same cycle as the swap.
    cycle(1, 4'd4, 16'h5A5A, 1, 1, 0, '0);
    checks++; if (bank_rd !== 1'b0 || frame_cnt !== 8'd1 || swap_pending !== 1'b0) begin errors++; $display("FAIL basic_swap got bank_rd=%b frame=%0d pend=%b exp 0/1/0", bank_rd, frame_cnt, swap_pending); end
    cycle(0, '0, '0, 0, 0, 1, 4'd3);
    e = exp_q.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== e || e !== 16'hA5A5) begin errors++; $display("FAIL basic_read3 got valid=%b data=%h exp 1/%h", rd_valid, rd_data, e); end
    cycle(0, '0, '0, 0, 0, 1, 4'd4);
    e = exp_q.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== e) begin errors++; $display("FAIL basic_last_pixel got valid=%b data=%h exp 1/%h", rd_valid, rd_data, e); end
    cycle(0, '0, '0, 0, 0, 0, '0);
    checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h5A5A) begin errors++; $display("FAIL basic_hold got valid=%b data=%h exp 0/5a5a", rd_valid, rd_data); end
  endtask

  task automatic test_wait();
    logic [TDW-1:0] e;
    do_reset();
    cycle(1, 4'd5, 16'h1234, 0, 0, 0, '0);
    cycle(0, '0, '0, 1, 0, 0, '0);
    checks++; if (swap_pending !== 1'b1 || bank_wr !== 1'b0) begin errors++; $display("FAIL wait_enter got pend=%b bank_wr=%b exp 1/0", swap_pending, bank_wr); end
    for (int i = 0; i < 4; i++) cycle(1, 4'd5, 16'hDEAD, 0, 0, 0, '0);
    cycle(0, '0, '0, 1, 0, 0, '0);
    checks++; if (drop_cnt !== 16'd4 || swap_pending !== 1'b1) begin errors++; $display("FAIL wait_drops got drop=%0d pend=%b exp 4/1", drop_cnt, swap_pending); end
    cycle(0, '0, '0, 0, 1, 0, '0);
    checks++; if (bank_wr !== 1'b1 || bank_rd !== 1'b0 || swap_pending !== 1'b0 || frame_cnt !== 8'd1) begin errors++; $display("FAIL wait_swap got bw=%b br=%b pend=%b frame=%0d exp 1/0/0/1", bank_wr, bank_rd, swap_pending, frame_cnt); end
    cycle(0, '0, '0, 0, 0, 1, 4'd5);
    e = exp_q.pop_front();
    checks++; if (rd_data !== e || e !== 16'h1234) begin errors++; $display("FAIL wait_mem_kept got %h exp %h", rd_data, e); end
  endtask

  task automatic test_repeat();
    logic [TDW-1:0] e;
    cycle(0, '0, '0, 0, 1, 0, '0);
    checks++; if (bank_rd !== 1'b0 || frame_cnt !== 8'd1) begin errors++; $display("FAIL repeat_bank got bank_rd=%b frame=%0d exp 0/1", bank_rd, frame_cnt); end
    cycle(0, '0, '0, 0, 0, 1, 4'd5);
    e = exp_q.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== e) begin errors++; $display("FAIL repeat_reread got %h exp %h", rd_data, e); end
  endtask

  task automatic test_bounds();
    logic [TDW-1:0] e;
    do_reset();
    cycle(1, 4'd2, 16'h2020, 0, 0, 0, '0);
    cycle(0, '0, '0, 1, 1, 0, '0);
    cycle(1, 4'd2, 16'h3030, 0, 0, 0, '0);
    cycle(1, 4'd9, 16'h9999, 1, 1, 0, '0);
    // bank_wr=0, bank_rd=1: out-of-range writes must not alias into bank 1.
    cycle(1, 4'd12, 16'hFFFF, 0, 0, 0, '0);
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bounds_drop12 got %0d exp 1", drop_cnt); end
    cycle(1, 4'd10, 16'hEEEE, 0, 0, 0, '0);
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL bounds_drop10 got %0d exp 2", drop_cnt); end
    cycle(0, '0, '0, 0, 0, 1, 4'd2);
    e = exp_q.pop_front();
    checks++; if (rd_data !== e || e !== 16'h3030) begin errors++; $display("FAIL bounds_mem_kept got %h exp %h", rd_data, e); end
    cycle(0, '0, '0, 0, 0, 1, 4'd9);
    e = exp_q.pop_front();
    checks++; if (rd_data !== e || e !== 16'h9999) begin errors++; $display("FAIL bounds_top_addr got %h exp %h", rd_data, e); end
    cycle(0, '0, '0, 0, 0, 1, 4'd12);
    e = exp_q.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h0000 || e !== 16'h0000) begin errors++; $display("FAIL bounds_read12 got valid=%b data=%h exp 1/0000", rd_valid, rd_data); end
  endtask

  task automatic test_edge();
    logic [TDW-1:0] e;
    // Read on the swap edge: bank_rd=1 holds 0x3030 at addr 2, bank 0 holds 0x2020.
    cycle(0, '0, '0, 1, 1, 1, 4'd2);
    e = exp_q.pop_front();
    checks++; if (rd_data !== e || e !== 16'h3030) begin errors++; $display("FAIL edge_swap_read got %h exp %h", rd_data, e); end
    cycle(0, '0, '0, 0, 0, 1, 4'd2);
    e = exp_q.pop_front();
    checks++; if (rd_data !== e || e !== 16'h2020) begin errors++; $display("FAIL edge_after_swap got %h exp %h", rd_data, e); end

    do_reset();
    for (int i = 0; i < 255; i++) cycle(0, '0, '0, 1, 1, 0, '0);
    checks++; if (frame_cnt !== 8'd255 || bank_wr !== 1'b1) begin errors++; $display("FAIL edge_frame255 got frame=%0d bw=%b exp 255/1", frame_cnt, bank_wr); end
    cycle(0, '0, '0, 1, 1, 0, '0);
    checks++; if (frame_cnt !== 8'd0 || frame_cnt !== m_frame) begin errors++; $display("FAIL edge_frame_wrap got %0d exp 0", frame_cnt); end

    for (int i = 0; i < 65534; i++) cycle(1, 4'd12, 16'h0, 0, 0, 0, '0);
    checks++; if (drop_cnt !== 16'hFFFE) begin errors++; $display("FAIL edge_drop_fffe got %h exp fffe", drop_cnt); end
    cycle(1, 4'd12, 16'h0, 0, 0, 0, '0);
    checks++; if (drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL edge_drop_ffff got %h exp ffff", drop_cnt); end
    cycle(1, 4'd12, 16'h0, 0, 0, 0, '0);
    cycle(1, 4'd12, 16'h0, 0, 0, 0, '0);
    checks++; if (drop_cnt !== 16'hFFFF || drop_cnt !== m_drop) begin errors++; $display("FAIL edge_drop_sat got %h exp ffff", drop_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    logic [TDW-1:0] e;
    do_reset();
    cycle(1, 4'd7, 16'h7777, 0, 0, 0, '0);
    cycle(1, 4'd8, 16'h1111, 1, 0, 0, '0);
    cycle(1, 4'd8, 16'h2222, 0, 0, 0, '0);
    checks++; if (swap_pending !== 1'b1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL midwait_enter got pend=%b drop=%0d exp 1/1", swap_pending, drop_cnt); end
    // Reset with a write and a read asserted: both must be ignored.
    rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0BAD; rd_en = 1'b1; rd_addr = 4'd7;
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    m_bank_wr = 1'b0; m_pending = 1'b0; m_frame = '0; m_drop = '0;
    checks++; if (swap_pending !== 1'b0 || bank_wr !== 1'b0 || frame_cnt !== 8'd0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL midwait_reset got pend=%b bw=%b frame=%0d drop=%0d exp 0/0/0/0", swap_pending, bank_wr, frame_cnt, drop_cnt); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 16'h0) begin errors++; $display("FAIL midwait_rd_reset got valid=%b data=%h exp 0/0000", rd_valid, rd_data); end
    cycle(0, '0, '0, 1, 1, 0, '0);
    cycle(0, '0, '0, 0, 0, 1, 4'd7);
    e = exp_q.pop_front();
    checks++; if (rd_valid !== 1'b1 || rd_data !== e || e !== 16'h7777) begin errors++; $display("FAIL midwait_data_kept got %h exp %h", rd_data, e); end
    cycle(0, '0, '0, 0, 0, 1, 4'd8);
    e = exp_q.pop_front();
    checks++; if (rd_data !== e || e !== 16'h1111) begin errors++; $display("FAIL midwait_last_pixel got %h exp %h", rd_data, e); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_repeat();
    test_bounds();
    test_edge();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuf_pingpong.md
FRAMEBUF_PINGPONG -- requirements
Module: framebuf_pingpong

Interface
REQ-001 Parameters SHALL be, one per line:
- AW, 19, address width of one frame bank.
- DW, 16, pixel word width.
- DEPTH, 2**AW, words per bank; legal range 1..2**AW.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- wr_en, in, 1, camera-side pixel write strobe.
- wr_addr, in, AW, pixel address in the write bank.
- wr_data, in, DW, pixel data.
- wr_frame_done, in, 1, one-cycle pulse: writer finished a frame.
- rd_en, in, 1, display-side read request.
- rd_addr, in, AW, pixel address in the read bank.
- rd_frame_done, in, 1, one-cycle pulse: reader finished a frame.
- rd_data, out, DW, registered read data.
- rd_valid, out, 1, rd_data valid pulse.
- bank_wr, out, 1, bank currently written.
- bank_rd, out, 1, bank currently read; always the inverse of bank_wr.
- swap_pending, out, 1, writer frame complete, waiting for reader.
- frame_cnt, out, 8, completed swaps, wraps 255->0.
- drop_cnt, out, 16, writes discarded, saturates at 65535.

Function
REQ-003 Storage SHALL be 2*DEPTH words of DW bits; the physical word is {bank, addr}.
REQ-004 The state machine SHALL have two states, FILL and WAIT_RD; swap_pending SHALL be 1 exactly in WAIT_RD.
REQ-005 In FILL, wr_en with wr_addr<DEPTH SHALL write wr_data to {bank_wr, wr_addr} at the clock edge.
REQ-006 In FILL, wr_en with wr_addr>=DEPTH SHALL be ignored and SHALL increment drop_cnt.
REQ-007 In WAIT_RD, every wr_en SHALL be discarded, memory SHALL be unchanged, and drop_cnt SHALL increment.
REQ-008 A write in the same cycle as wr_frame_done SHALL be accepted as the last pixel of the current frame, provided FILL and wr_addr<DEPTH.
REQ-009 In FILL with wr_frame_done=1 and rd_frame_done=0, the next state SHALL be WAIT_RD.
REQ-010 In FILL with wr_frame_done=1 and rd_frame_done=1 together, the block SHALL swap on that edge:
- bank_wr and bank_rd toggle;
- frame_cnt increments;
- the state stays FILL.
REQ-011 In WAIT_RD with rd_frame_done=1, the block SHALL swap (toggle banks, increment frame_cnt) and return to FILL.
REQ-012 In FILL with only rd_frame_done=1, banks SHALL NOT change; the reader re-reads the same bank (frame repeat).
REQ-013 In WAIT_RD, a wr_frame_done pulse SHALL be ignored and SHALL NOT change drop_cnt.
REQ-014 Read latency SHALL be 1 cycle: rd_en at edge N gives rd_data and rd_valid=1 after edge N+1.
REQ-015 When rd_en=0, rd_valid SHALL be 0 and rd_data SHALL hold its last value.
REQ-016 A read SHALL use bank_rd as it was before any swap on the same edge.
REQ-017 rd_addr>=DEPTH SHALL return rd_data=0 with rd_valid=1.
REQ-018 A same-cycle write and read SHALL never target the same bank, so no read-during-write hazard exists.
REQ-019 drop_cnt SHALL saturate at 0xFFFF; frame_cnt SHALL wrap modulo 256.

Reset
REQ-020 rst=1 at a clock edge SHALL set:
- state FILL, bank_wr=0, bank_rd=1, swap_pending=0;
- frame_cnt=0, drop_cnt=0;
- rd_data=0, rd_valid=0.
REQ-021 Memory contents SHALL NOT be cleared by reset.
REQ-022 During rst, writes and reads SHALL be ignored.
REQ-023 Reset asserted in WAIT_RD SHALL discard the pending swap.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Basic: reset; write 0xA5A5 to addr 3; pulse wr_frame_done and rd_frame_done together; read addr 3 -> rd_data=0xA5A5 one cycle later, bank_rd=0, frame_cnt=1.
- Wait: wr_frame_done alone -> swap_pending=1; 4 writes follow -> drop_cnt=4; rd_frame_done -> banks toggle, swap_pending=0, frame_cnt=1.
- Repeat: rd_frame_done alone in FILL -> bank_rd unchanged; the same data is re-read.
- Bounds: DEPTH=10; write addr 12 -> drop_cnt=1, memory unchanged; read addr 12 -> rd_data=0, rd_valid=1.
- Edge: read on the swap edge -> data comes from the old read bank; frame_cnt wraps after 256 swaps; drop_cnt holds at 0xFFFF after 65536 drops.
- Reset mid-wait: enter WAIT_RD, assert rst -> swap_pending=0, bank_wr=0, counters=0, previously written data still readable after the next swap.
